fp16_sum_seq: RTL and testbench

Streaming reduction sequencer that sums a packet of floating-point elements using an external pipelined `fp16_add` instance. It sits on both sides of the adder: it drives the adder operands and consumes the adder result `ADD_LAT` cycles later. It interleaves `ADD_LAT` partial-sum lanes so that back-to-back elements are accepted at full rate, then merges the lanes and presents one sum per packet on a valid/ready output.

---
 rtl/fp16_pkg.sv | 22 ++
 rtl/fp16_sum_seq_if.sv | 39 +++
 rtl/fp16_sum_tag_pipe.sv | 35 +++
 rtl/fp16_sum_seq.sv | 145 ++++++++++++++
 tb/tb_fp16_sum_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared float helpers and sequencer state encoding for the fp16_sum block.
package fp16_pkg;

  function automatic int exp_w(input int width);
    return (width == 16) ? 5 : (width == 32) ? 8 : 11;
  endfunction

  function automatic int mant_w(input int width);
    return width - 1 - exp_w(width);
  endfunction

  function automatic int bias(input int width);
    return (1 << (exp_w(width) - 1)) - 1;
  endfunction

  localparam logic [15:0] P_ZERO = 16'h0000;
  localparam logic [15:0] N_ZERO = 16'h8000;
  localparam logic [15:0] QNAN   = 16'h7E00;

  typedef enum logic [1:0] {ACCUM, DRAIN, MERGE, OUT} sum_state_e;

endpackage

// File: rtl/fp16_sum_seq_if.sv
// Element stream, sum stream and adder operand/result bundle for fp16_sum_seq.
// out_count exists only when FP16_SUM_CNT_EN is defined.
interface fp16_sum_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_result;
`ifdef FP16_SUM_CNT_EN
  logic [CNT_W-1:0] out_count;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  modport slave (
    input  in_valid, in_data, in_last, out_ready, add_result,
    output in_ready, out_valid, out_data, add_a, add_b
`ifdef FP16_SUM_CNT_EN
    , output out_count
`endif
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, add_result,
    input  in_ready, out_valid, out_data, add_a, add_b
`ifdef FP16_SUM_CNT_EN
    , input out_count
`endif
  );

endinterface

// File: rtl/fp16_sum_tag_pipe.sv
// Tag shift register tracking adder issues; the tail tag qualifies add_result.
module fp16_sum_tag_pipe #(
  parameter int DEPTH  = 2,
  parameter int LANE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_lane,
  input  logic              in_merge,
  output logic              ret_valid,
  output logic [LANE_W-1:0] ret_lane,
  output logic              ret_merge
);
  typedef struct packed {
    logic              vld;
    logic [LANE_W-1:0] lane;
    logic              merge;
  } tag_t;

  tag_t             tag_in;
  tag_t [DEPTH-1:0] pipe;

  assign tag_in = '{vld: in_valid, lane: in_lane, merge: in_merge};

  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[DEPTH-2:0], tag_in};
  end

  assign ret_valid = pipe[DEPTH-1].vld;
  assign ret_lane  = pipe[DEPTH-1].lane;
  assign ret_merge = pipe[DEPTH-1].merge;

endmodule

// File: rtl/fp16_sum_seq.sv
// Packet sum sequencer around an external ADD_LAT-deep adder: interleaved lanes,
// then a serial lane merge. FP16_SUM_CNT_EN adds a per-packet element count.
module fp16_sum_seq
  import fp16_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  fp16_sum_seq_if.slave bus
);
  localparam int LANE_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_MERGE = MERGE;
  localparam logic [1:0] ST_OUT   = OUT;

  logic [1:0]                    state;
  logic [ADD_LAT-1:0][WIDTH-1:0] lanes;
  logic [ADD_LAT-1:0]            busy, busy_nxt;
  logic [LANE_W-1:0]             ptr, ptr_nxt;
  logic [LANE_W-1:0]             m_idx;
  logic                          m_wait;
  logic [WIDTH-1:0]              out_data_q;
  logic [WIDTH-1:0]              add_a, add_b;

  logic              ret_valid, ret_merge;
  logic [LANE_W-1:0] ret_lane;
  logic              ret_acc, ret_mrg, bypass, in_ready;
  logic              accept, m_issue, m_final, load_out, out_fire;

  fp16_sum_tag_pipe #(.DEPTH(ADD_LAT), .LANE_W(LANE_W)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept | m_issue),
    .in_lane  (ptr),
    .in_merge (m_issue),
    .ret_valid(ret_valid),
    .ret_lane (ret_lane),
    .ret_merge(ret_merge)
  );

  assign ret_acc  = ret_valid && !ret_merge;
  assign ret_mrg  = ret_valid && ret_merge;
  // A lane whose result lands this cycle can be reissued at once via bypass.
  assign bypass   = ret_acc && (ret_lane == ptr);
  assign in_ready = !rst && (state == ST_ACCUM) && (!busy[ptr] || bypass);
  assign accept   = bus.in_valid && in_ready;
  assign m_issue  = !rst && (state == ST_MERGE) && !m_wait;
  assign m_final  = (m_idx == LANE_W'(ADD_LAT - 1));
  assign load_out = (state == ST_MERGE) && m_wait && ret_mrg && m_final;
  assign out_fire = (state == ST_OUT) && bus.out_ready;
  assign ptr_nxt  = (ptr == LANE_W'(ADD_LAT - 1)) ? '0 : ptr + 1'b1;

  // Merges accumulate into lane 0, so operand a is always lane 0.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (accept) begin
      add_a = bypass ? bus.add_result : lanes[ptr];
      add_b = bus.in_data;
    end else if (m_issue) begin
      add_a = lanes[0];
      add_b = lanes[m_idx];
    end
  end

  always_comb begin
    busy_nxt = busy;
    if (ret_acc) busy_nxt[ret_lane] = 1'b0;
    if (accept)  busy_nxt[ptr]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACCUM;
      lanes      <= '0;
      busy       <= '0;
      ptr        <= '0;
      m_idx      <= LANE_W'(1);
      m_wait     <= 1'b0;
      out_data_q <= '0;
    end else begin
      busy <= busy_nxt;
      if (ret_acc) lanes[ret_lane] <= bus.add_result;
      if (accept)  ptr <= ptr_nxt;
      case (state)
        ST_ACCUM: if (accept && bus.in_last) state <= ST_DRAIN;
        ST_DRAIN: if (busy_nxt == '0) begin
          state  <= ST_MERGE;
          m_idx  <= LANE_W'(1);
          m_wait <= 1'b0;
        end
        ST_MERGE: begin
          if (m_issue) begin
            m_wait <= 1'b1;
          end else if (ret_mrg) begin
            m_wait <= 1'b0;
            if (m_final) begin
              out_data_q <= bus.add_result;
              state      <= ST_OUT;
            end else begin
              lanes[0] <= bus.add_result;
              m_idx    <= m_idx + 1'b1;
            end
          end
        end
        ST_OUT: if (bus.out_ready) begin
          lanes <= '0;
          ptr   <= '0;
          state <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

`ifdef FP16_SUM_CNT_EN
  logic [CNT_W-1:0] cnt, out_count_q;

  always_ff @(posedge clk) begin
    if (rst || out_fire) begin
      cnt         <= '0;
      out_count_q <= '0;
    end else begin
      if (accept && (cnt != '1)) cnt <= cnt + 1'b1;
      if (load_out) out_count_q <= cnt;
    end
  end

  assign bus.out_count = out_count_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;

endmodule

// File: tb/tb_fp16_sum_seq.sv
// Directed bench for fp16_sum_seq with a behavioural fp16 adder pipeline and a
// scoreboard of expected packet sums (and counts when FP16_SUM_CNT_EN is set).
module tb_fp16_sum_seq;
  import fp16_pkg::*;

  localparam int WIDTH   = 16;
  localparam int ADD_LAT = 2;
  localparam int CNT_W   = 16;

  typedef struct {
    logic [15:0] data;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_err = 0, cyc = 0, last_acc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp16_sum_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fp16_sum_seq #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference fp16 add: truncation, flush-to-zero, default qNaN.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic sa, sb_, sr;
    int   ea, eb, er, fa, fb, s, t;
    sa = a[15]; sb_ = b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return QNAN;
    if (ea == 31 && eb == 31) return (sa == sb_) ? a : QNAN;
    if (ea == 31) return a;
    if (eb == 31) return b;
    if (ea == 0) return (eb == 0) ? {sa & sb_, 15'h0} : b;
    if (eb == 0) return a;
    fa = int'({1'b1, a[9:0]}) << 3;
    fb = int'({1'b1, b[9:0]}) << 3;
    if (eb > ea || (eb == ea && fb > fa)) begin
      t = ea; ea = eb; eb = t;
      t = fa; fa = fb; fb = t;
      sr = sa; sa = sb_; sb_ = sr;
    end
    fb = (ea - eb > 13) ? 0 : fb >> (ea - eb);
    s  = (sa == sb_) ? fa + fb : fa - fb;
    if (s == 0) return P_ZERO;
    er = ea;
    while (s >= (1 << 14)) begin s = s >> 1; er++; end
    while (s < (1 << 13)) begin s = s << 1; er--; end
    if (er >= 31) return {sa, 5'h1F, 10'h0};
    if (er <= 0) return {sa, 15'h0};
    return {sa, er[4:0], s[12:3]};
  endfunction

  logic [15:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= fadd(bus.add_a, bus.add_b);
    for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign bus.add_result = add_pipe[ADD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [15:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  // Output monitor: every handshake pops and compares one scoreboard entry.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_pop: observed output %h, expected none", bus.out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
`ifdef FP16_SUM_CNT_EN
        chk("out_count", 32'(bus.out_count), e.cnt);
`endif
      end
    end
  end

  // Called just after a negedge; returns at the negedge after the accept.
  task automatic send(input logic [15:0] d, input logic last, input bit chk_rdy);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    if (chk_rdy) chk("in_ready_stream", 32'(bus.in_ready), 1);
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w == 100) chk("in_ready_timeout", w, 0);
    last_acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_cyc);
    int w = 0;
    #1;
    while (bus.out_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("out_valid_seen", 32'(bus.out_valid), 1);
    if (exp_cyc >= 0) chk("out_latency", cyc, exp_cyc);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_add_a",     32'(bus.add_a), 0);
    chk("rst_add_b",     32'(bus.add_b), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 1);
`ifdef FP16_SUM_CNT_EN
    chk("rst_out_count", 32'(bus.out_count), 0);
`endif
    @(negedge clk);

    // 1+2+3+4 streamed back to back
    expect_out(16'h4900, 4);
    send(16'h3C00, 1'b0, 1'b1);
    send(16'h4000, 1'b0, 1'b1);
    send(16'h4200, 1'b0, 1'b1);
    send(16'h4400, 1'b1, 1'b1);
    #1;
    chk("in_ready_drain", 32'(bus.in_ready), 0);
    wait_valid(last_acc + 6);
    wait_drain();

    // single-element packets
    expect_out(16'h3C00, 1);
    send(16'h3C00, 1'b1, 1'b1);
    wait_drain();
    expect_out(16'hC000, 1);
    send(16'hC000, 1'b1, 1'b1);
    wait_drain();

    // +Inf + -Inf
    expect_out(QNAN, 2);
    send(16'h7C00, 1'b0, 1'b1);
    send(16'hFC00, 1'b1, 1'b1);
    wait_drain();

    // gapped input, then output backpressure
    bus.out_ready = 1'b0;
    expect_out(16'h4200, 3);
    send(16'h3C00, 1'b0, 1'b0);
    @(negedge clk);
    send(16'h3C00, 1'b0, 1'b0);
    @(negedge clk);
    send(16'h3C00, 1'b1, 1'b0);
    wait_valid(-1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",    32'(bus.out_valid), 1);
      chk("hold_data",     32'(bus.out_data), 32'h4200);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
`ifdef FP16_SUM_CNT_EN
      chk("hold_count",    32'(bus.out_count), 3);
`endif
      @(negedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    chk("hs_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    #1;
    chk("post_hs_in_ready",  32'(bus.in_ready), 1);
    chk("post_hs_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);

    // reset while the merge add is in flight
    send(16'h3C00, 1'b0, 1'b1);
    send(16'h3C00, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_in_ready",  32'(bus.in_ready), 1);
    chk("mid_rst_out_data",  32'(bus.out_data), 0);
    expect_out(16'h4400, 2);
    send(16'h4000, 1'b0, 1'b1);
    send(16'h4000, 1'b1, 1'b1);
    wait_drain();

    // two packets queued back to back
    expect_out(16'h4000, 2);
    expect_out(16'h4200, 1);
    send(16'h3C00, 1'b0, 1'b1);
    send(16'h3C00, 1'b1, 1'b1);
    send(16'h4200, 1'b1, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
